// File: rtl/spi_regbank_if.sv
// spi_regbank_if: SPI pin bundle between an external SPI master and the spi_regbank slave.
interface spi_regbank_if;
    logic spi_cs_n;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_cs_n, output spi_clk, output spi_mosi, input spi_miso);
    modport slave  (input spi_cs_n, input spi_clk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_regbank.sv
// spi_regbank: SPI mode-0 slave exposing NUM_CFG read/write and NUM_STS read-only registers.
// Macro SPI_REGBANK_BURST_EN enables auto-increment bursts; otherwise each frame carries one data word.
module spi_regbank #(
    parameter int NUM_CFG = 8,
    parameter int NUM_STS = 4,
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 7,
    localparam int STS_BITS = (NUM_STS > 0) ? NUM_STS * WIDTH : 1
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     ena,
    spi_regbank_if.slave             spi,
    output logic [NUM_CFG*WIDTH-1:0] cfg_regs,
    output logic [NUM_CFG-1:0]       cfg_wr_stb,
    input  logic [STS_BITS-1:0]      sts_regs,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    localparam logic [7:0] NTOT = 8'(NUM_CFG + NUM_STS);
    localparam logic [4:0] LAST = 5'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [2:0]        cs_s_q, sck_s_q;
    logic [1:0]        mosi_s_q;
    logic              sck_rise_q, sck_fall_q, mosi_q;
    logic [4:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc, rd_addr;
    logic              wr_q, wr_d, done_q, done_d;
    logic [WIDTH-2:0]  sr_q, sr_d;
    logic [WIDTH-1:0]  tx_q, tx_d, shift_in, rd_word;
    logic [WIDTH-1:0]  cfg_q [NUM_CFG];
    logic [WIDTH-1:0]  cfg_d [NUM_CFG];
    logic [NUM_CFG-1:0] stb_q, stb_d;
    logic              cs_fall, cs_rise, sck_rise, sck_fall, bit_evt, bit_in;

    // Bit 0 and 1 of each chain are the synchroniser, bit 2 is the previous sample for edge detection
    assign cs_fall  = cs_s_q[2] & ~cs_s_q[1];
    assign cs_rise  = ~cs_s_q[2] & cs_s_q[1];
    assign sck_rise = ~sck_s_q[2] & sck_s_q[1];
    assign sck_fall = sck_s_q[2] & ~sck_s_q[1];

    // A SCLK rise arriving together with cs_n rising is consumed now, ahead of the abort
    assign bit_evt  = ena && (state_q != IDLE) && (sck_rise_q || (cs_rise && sck_rise));
    assign bit_in   = sck_rise_q ? mosi_q : mosi_s_q[1];
    assign shift_in = {sr_q, bit_in};
    assign addr_inc = (8'(addr_q) == NTOT - 8'd1) ? '0 : addr_q + ADDR_W'(1);
    assign rd_addr  = (state_q == CMD) ? shift_in[ADDR_W-1:0] : addr_inc;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CFG; i++)
            if (8'(rd_addr) == 8'(i)) rd_word = cfg_q[i];
        for (int j = 0; j < NUM_STS; j++)
            if (8'(rd_addr) == 8'(NUM_CFG + j)) rd_word = sts_regs[j*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        done_d  = done_q;
        sr_d    = sr_q;
        tx_d    = tx_q;
        cfg_d   = cfg_q;
        stb_d   = '0;
        case (state_q)
            IDLE: begin
                if (ena && cs_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    wr_d    = 1'b0;
                    done_d  = 1'b0;
                end
            end
            CMD: begin
                if (bit_evt) begin
                    sr_d  = shift_in[WIDTH-2:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        wr_d    = shift_in[7];
                        addr_d  = shift_in[ADDR_W-1:0];
                        tx_d    = shift_in[7] ? '0 : rd_word;
                    end
                end
            end
            DATA: begin
                if (bit_evt && !done_q) begin
                    sr_d  = shift_in[WIDTH-2:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST) begin
                        cnt_d  = '0;
                        addr_d = addr_inc;
                        for (int i = 0; i < NUM_CFG; i++) begin
                            if (wr_q && 8'(addr_q) == 8'(i)) begin
                                cfg_d[i] = shift_in;
                                stb_d[i] = 1'b1;
                            end
                        end
`ifdef SPI_REGBANK_BURST_EN
                        tx_d = wr_q ? '0 : rd_word;
`else
                        done_d = 1'b1;
                        tx_d   = '0;
`endif
                    end
                end else if (sck_fall_q && !done_q && cnt_q != '0) begin
                    // The fall right after a word load leaves the MSB in place
                    tx_d = {tx_q[WIDTH-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
        if (!ena || cs_rise) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // cs_n chain resets to "selected" so a frame already in progress cannot look like a new falling edge
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cs_s_q     <= '0;
            sck_s_q    <= '0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            stb_q      <= '0;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
        end else begin
            cs_s_q     <= {cs_s_q[1:0], spi.spi_cs_n};
            sck_s_q    <= {sck_s_q[1:0], spi.spi_clk};
            sck_rise_q <= sck_rise;
            sck_fall_q <= sck_fall;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            stb_q      <= stb_d;
            cfg_q      <= cfg_d;
        end
    end

    always_ff @(posedge clk) begin
        mosi_s_q <= {mosi_s_q[0], spi.spi_mosi};
        mosi_q   <= mosi_s_q[1];
        sr_q     <= sr_d;
        tx_q     <= tx_d;
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign cfg_regs[g*WIDTH +: WIDTH] = cfg_q[g];
    end

    assign cfg_wr_stb   = stb_q;
    assign busy         = (state_q != IDLE);
    assign spi.spi_miso = ena && (state_q == DATA) && !wr_q && !done_q && tx_q[WIDTH-1];

endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: directed bench for spi_regbank (NUM_CFG=8, NUM_STS=4, WIDTH=8) driving a mode-0 master.
`timescale 1ns/1ps
module tb_spi_regbank;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        ena = 1'b1;
    logic [63:0] cfg_regs;
    logic [7:0]  cfg_wr_stb;
    logic [31:0] sts_regs;
    logic        busy;

    spi_regbank_if spi ();

    spi_regbank #(.NUM_CFG(8), .NUM_STS(4), .WIDTH(8), .ADDR_W(7)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .spi(spi), .cfg_regs(cfg_regs),
        .cfg_wr_stb(cfg_wr_stb), .sts_regs(sts_regs), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_cfg [8];
    int          exp_stb [8];
    int          stb_cnt [8];
    logic        clr_stb = 1'b0;
    logic [31:0] tx_w [8];
    logic [31:0] rx_w [8];
    logic [31:0] rx_cmd;

    always @(posedge clk)
        for (int i = 0; i < 8; i++)
            stb_cnt[i] <= clr_stb ? 0 : stb_cnt[i] + int'(cfg_wr_stb[i]);

    function automatic logic [63:0] exp_vec();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = exp_cfg[i];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_stb();
        clr_stb = 1'b1;
        tick(1);
        clr_stb = 1'b0;
        for (int i = 0; i < 8; i++) exp_stb[i] = 0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, output logic [31:0] r);
        r = '0;
        for (int b = n - 1; b >= 0; b--) begin
            spi.spi_mosi = v[b];
            tick(HALF);
            r = {r[30:0], spi.spi_miso};
            spi.spi_clk = 1'b1;
            tick(HALF);
            spi.spi_clk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi.spi_cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end();
        tick(HALF);
        spi.spi_cs_n = 1'b1;
        tick(8);
    endtask

    task automatic frame(input logic [7:0] cmd, input int nw);
        cs_begin();
        send_bits({24'd0, cmd}, 8, rx_cmd);
        for (int w = 0; w < nw; w++) send_bits(tx_w[w], 8, rx_w[w]);
        cs_end();
    endtask

    task automatic test_reset();
        tick(1);
        rstb = 1'b0;
        tick(3);
        n_vec++; if (cfg_regs !== 64'h0) begin n_err++; $display("FAIL rst_cfg: got %h want 0", cfg_regs); end
        n_vec++; if (cfg_wr_stb !== 8'h0) begin n_err++; $display("FAIL rst_stb: got %h want 0", cfg_wr_stb); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (spi.spi_miso !== 1'b0) begin n_err++; $display("FAIL rst_miso: got %b want 0", spi.spi_miso); end
        rstb = 1'b1;
        tick(4);
        clear_stb();
    endtask

    task automatic test_write();
        logic [31:0] r;
        spi.spi_cs_n = 1'b0;
        tick(2);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_rise_early: got %b want 0", busy); end
        tick(1);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_rise: got %b want 1", busy); end
        tick(HALF - 3);
        send_bits(32'h81, 8, r);
        send_bits(32'h52, 7, r);
        n_vec++; if (r[6:0] !== 7'h0) begin n_err++; $display("FAIL wr_miso: got %h want 0", r[6:0]); end
        spi.spi_mosi = 1'b1;
        tick(HALF);
        spi.spi_clk = 1'b1;
        tick(3);
        n_vec++; if (cfg_regs[15:8] !== 8'h00 || cfg_wr_stb !== 8'h00) begin n_err++; $display("FAIL wr_early: got cfg1=%h stb=%h want 00/00", cfg_regs[15:8], cfg_wr_stb); end
        tick(1);
        n_vec++; if (cfg_regs[15:8] !== 8'hA5 || cfg_wr_stb !== 8'h02) begin n_err++; $display("FAIL wr_edge: got cfg1=%h stb=%h want a5/02", cfg_regs[15:8], cfg_wr_stb); end
        tick(1);
        n_vec++; if (cfg_wr_stb !== 8'h00) begin n_err++; $display("FAIL wr_stb_width: got %h want 00", cfg_wr_stb); end
        spi.spi_clk = 1'b0;
        cs_end();
        exp_cfg[1] = 8'hA5;
        exp_stb[1] = 1;
        n_vec++; if (cfg_regs !== exp_vec()) begin n_err++; $display("FAIL wr_cfg: got %h want %h", cfg_regs, exp_vec()); end
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (stb_cnt[i] !== exp_stb[i]) begin n_err++; $display("FAIL wr_stbcnt[%0d]: got %0d want %0d", i, stb_cnt[i], exp_stb[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        clear_stb();
        cs_begin();
        send_bits(32'h82, 8, r);
        send_bits(32'h5, 3, r);
        rstb = 1'b0;
        tick(2);
        n_vec++; if (cfg_regs !== 64'h0) begin n_err++; $display("FAIL mrst_cfg: got %h want 0", cfg_regs); end
        n_vec++; if (busy !== 1'b0 || spi.spi_miso !== 1'b0) begin n_err++; $display("FAIL mrst_busy_miso: got %b/%b want 0/0", busy, spi.spi_miso); end
        rstb = 1'b1;
        for (int i = 0; i < 8; i++) exp_cfg[i] = 8'h00;
        send_bits(32'h1F, 5, r);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_ignore: got busy %b want 0", busy); end
        cs_end();
        n_vec++; if (cfg_regs !== exp_vec()) begin n_err++; $display("FAIL mrst_nowrite: got %h want %h", cfg_regs, exp_vec()); end
        tx_w[0] = 32'h5A;
        frame(8'h82, 1);
        exp_cfg[2] = 8'h5A;
        exp_stb[2] = 1;
        n_vec++; if (cfg_regs !== exp_vec()) begin n_err++; $display("FAIL mrst_next: got %h want %h", cfg_regs, exp_vec()); end
        n_vec++; if (rx_w[0][7:0] !== 8'h00) begin n_err++; $display("FAIL mrst_wrmiso: got %h want 00", rx_w[0][7:0]); end
        n_vec++; if (stb_cnt[2] !== 1 || stb_cnt[1] !== 0) begin n_err++; $display("FAIL mrst_stb: got %0d/%0d want 1/0", stb_cnt[2], stb_cnt[1]); end
    endtask

    task automatic test_read();
        tx_w[0] = 32'h0;
        frame(8'h02, 1);
        n_vec++; if (rx_cmd[7:0] !== 8'h00) begin n_err++; $display("FAIL rd_cmd_miso: got %h want 00", rx_cmd[7:0]); end
        n_vec++; if (rx_w[0][7:0] !== 8'h5A) begin n_err++; $display("FAIL rd_cfg2: got %h want 5a", rx_w[0][7:0]); end
        frame(8'h09, 1);
        n_vec++; if (rx_w[0][7:0] !== 8'h5D) begin n_err++; $display("FAIL rd_sts1: got %h want 5d", rx_w[0][7:0]); end
        frame(8'h30, 1);
        n_vec++; if (rx_w[0][7:0] !== 8'h00) begin n_err++; $display("FAIL rd_unmapped: got %h want 00", rx_w[0][7:0]); end
    endtask

    task automatic test_partial();
        logic [31:0] r;
        tx_w[0] = 32'h3E;
        frame(8'h83, 1);
        exp_cfg[3] = 8'h3E;
        clear_stb();
        cs_begin();
        send_bits(32'h83, 8, r);
        send_bits(32'h16, 5, r);
        spi.spi_cs_n = 1'b1;
        tick(2);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL part_busy_hold: got %b want 1", busy); end
        tick(1);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL part_busy_drop: got %b want 0", busy); end
        tick(6);
        n_vec++; if (cfg_regs !== exp_vec()) begin n_err++; $display("FAIL part_cfg: got %h want %h", cfg_regs, exp_vec()); end
        n_vec++; if (stb_cnt[3] !== 0) begin n_err++; $display("FAIL part_stb: got %0d want 0", stb_cnt[3]); end
    endtask

    task automatic test_ena();
        logic [31:0] r;
        clear_stb();
        cs_begin();
        send_bits(32'h84, 8, r);
        send_bits(32'hF, 4, r);
        ena = 1'b0;
        tick(4);
        n_vec++; if (busy !== 1'b0 || spi.spi_miso !== 1'b0) begin n_err++; $display("FAIL ena_abort: got busy=%b miso=%b want 0/0", busy, spi.spi_miso); end
        ena = 1'b1;
        send_bits(32'hF, 4, r);
        cs_end();
        n_vec++; if (cfg_regs !== exp_vec() || stb_cnt[4] !== 0) begin n_err++; $display("FAIL ena_nowrite: got %h stb=%0d want %h stb=0", cfg_regs, stb_cnt[4], exp_vec()); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] r;
        clear_stb();
        cs_begin();
        send_bits(32'h85, 8, r);
        send_bits(32'h35, 7, r);
        spi.spi_mosi = 1'b1;
        tick(HALF);
        spi.spi_clk  = 1'b1;
        spi.spi_cs_n = 1'b1;
        tick(6);
        spi.spi_clk = 1'b0;
        tick(6);
        exp_cfg[5] = 8'h6B;
        n_vec++; if (cfg_regs !== exp_vec()) begin n_err++; $display("FAIL sim_cfg: got %h want %h", cfg_regs, exp_vec()); end
        n_vec++; if (stb_cnt[5] !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL sim_stb_busy: got %0d/%b want 1/0", stb_cnt[5], busy); end
    endtask

`ifdef SPI_REGBANK_BURST_EN
    task automatic test_burst_write();
        clear_stb();
        for (int w = 0; w < 7; w++) tx_w[w] = 32'h11 * (w + 1);
        frame(8'h86, 7);
        exp_cfg[6] = 8'h11;
        exp_cfg[7] = 8'h22;
        exp_cfg[0] = 8'h77;
        exp_stb[6] = 1;
        exp_stb[7] = 1;
        exp_stb[0] = 1;
        n_vec++; if (cfg_regs !== exp_vec()) begin n_err++; $display("FAIL bw_cfg: got %h want %h", cfg_regs, exp_vec()); end
        for (int i = 0; i < 8; i++) begin
            n_vec++; if (stb_cnt[i] !== exp_stb[i]) begin n_err++; $display("FAIL bw_stbcnt[%0d]: got %0d want %0d", i, stb_cnt[i], exp_stb[i]); end
        end
    endtask

    task automatic test_burst_read();
        logic [31:0] lo, hi;
        logic [7:0]  want [6];
        cs_begin();
        send_bits(32'h07, 8, rx_cmd);
        send_bits(32'h0, 8, rx_w[0]);
        send_bits(32'h0, 8, rx_w[1]);
        send_bits(32'h0, 4, hi);
        sts_regs[15:8] = 8'hA2;
        send_bits(32'h0, 4, lo);
        rx_w[2] = {24'd0, hi[3:0], lo[3:0]};
        sts_regs[15:8] = 8'h5D;
        for (int w = 3; w < 6; w++) send_bits(32'h0, 8, rx_w[w]);
        cs_end();
        want[0] = 8'h22; want[1] = 8'h3C; want[2] = 8'h5D;
        want[3] = 8'h7E; want[4] = 8'h0F; want[5] = 8'h77;
        n_vec++; if (rx_cmd[7:0] !== 8'h00) begin n_err++; $display("FAIL br_cmd_miso: got %h want 00", rx_cmd[7:0]); end
        for (int w = 0; w < 6; w++) begin
            n_vec++; if (rx_w[w][7:0] !== want[w]) begin n_err++; $display("FAIL br_word[%0d]: got %h want %h", w, rx_w[w][7:0], want[w]); end
        end
    endtask
`else
    task automatic test_single_word();
        clear_stb();
        tx_w[0] = 32'hC3;
        tx_w[1] = 32'h3C;
        frame(8'h80, 2);
        exp_cfg[0] = 8'hC3;
        n_vec++; if (cfg_regs !== exp_vec()) begin n_err++; $display("FAIL sw_cfg: got %h want %h", cfg_regs, exp_vec()); end
        n_vec++; if (stb_cnt[0] !== 1 || stb_cnt[1] !== 0) begin n_err++; $display("FAIL sw_stb: got %0d/%0d want 1/0", stb_cnt[0], stb_cnt[1]); end
        frame(8'h02, 2);
        n_vec++; if (rx_w[0][7:0] !== 8'h5A) begin n_err++; $display("FAIL sw_rd0: got %h want 5a", rx_w[0][7:0]); end
        n_vec++; if (rx_w[1][7:0] !== 8'h00) begin n_err++; $display("FAIL sw_rd1: got %h want 00", rx_w[1][7:0]); end
    endtask
`endif

    initial begin
        spi.spi_cs_n = 1'b1;
        spi.spi_clk  = 1'b0;
        spi.spi_mosi = 1'b0;
        sts_regs     = 32'h0F7E5D3C;
        for (int i = 0; i < 8; i++) begin
            exp_cfg[i] = 8'h00;
            exp_stb[i] = 0;
            stb_cnt[i] = 0;
        end
        test_reset();
        test_write();
        test_reset_midframe();
        test_read();
        test_partial();
        test_ena();
        test_simultaneous();
`ifdef SPI_REGBANK_BURST_EN
        test_burst_write();
        test_burst_read();
`else
        test_single_word();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
